// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential floating-point adder/subtractor.
// Widths are passed as arguments because a package cannot take parameters.
package fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    localparam int FLAGS_W       = 4;
    localparam int FLAG_INVALID  = 3;
    localparam int FLAG_OVERFLOW = 2;
    localparam int FLAG_UNDERFLW = 1;
    localparam int FLAG_INEXACT  = 0;

    localparam int FP_MAX_W = 64;

    // Quiet NaN with positive sign, all-ones exponent and only the fraction MSB set.
    function automatic logic [FP_MAX_W-1:0] canonical_nan(input int exp_w, input int man_w);
        logic [FP_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < exp_w; i++) begin
            v[man_w + i] = 1'b1;
        end
        v[man_w - 1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack of one operand into sign, exponent, mantissa with hidden bit and class.
// Subnormals are flushed: a zero exponent always classifies as zero with a zero mantissa.
module fp_classify
    import fp_pkg::*;
#(
    parameter  int EXP_W = 5,
    parameter  int MAN_W = 10,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0]     op_i,
    output logic             sign_o,
    output logic [EXP_W-1:0] exp_o,
    output logic [MAN_W:0]   man_o,
    output fp_class_e        cls_o
);

    logic [MAN_W-1:0] frac;

    assign sign_o = op_i[W-1];
    assign exp_o  = op_i[W-2 -: EXP_W];
    assign frac   = op_i[MAN_W-1:0];

    always_comb begin
        cls_o = CLS_NORM;
        man_o = {1'b1, frac};
        if (exp_o == '0) begin
            cls_o = CLS_ZERO;
            man_o = '0;
        end else if (exp_o == '1) begin
            cls_o = (frac == '0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multicycle floating-point adder/subtractor: one bit of alignment or normalisation per cycle,
// round-to-nearest-even, with flushed subnormals and inf/NaN/overflow handling.
module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter  int EXP_W = 5,
    parameter  int MAN_W = 10,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic               op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       result,
    output logic [FLAGS_W-1:0] flags,
    output state_e             state_dbg
);

    // Handshakes: an operand pair transfers on a rising edge with in_valid && in_ready
    // (in_ready only in IDLE); a result transfers with out_valid && out_ready (out_valid
    // only in DONE), and result/flags hold steady until it does. Other cycles are ignored.

    localparam int MW        = MAN_W + 5;   // {carry, hidden, frac, G, R, S}
    localparam int SHIFT_MAX = MAN_W + 3;
    localparam logic [FP_MAX_W-1:0] NAN_WIDE = canonical_nan(EXP_W, MAN_W);
    localparam logic [W-1:0]        QNAN     = NAN_WIDE[W-1:0];
    localparam logic [EXP_W:0]      EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0]      EXP_LIM  = {1'b0, {EXP_W{1'b1}}};

    state_e               state_q, state_d;
    logic [MW-1:0]        ma_q, ma_d;
    logic [MW-1:0]        mb_q, mb_d;
    logic [EXP_W:0]       e_q, e_d;
    logic [EXP_W-1:0]     diff_q, diff_d;
    logic                 sign_q, sign_d;
    logic                 sub_q, sub_d;
    logic [W-1:0]         res_q, res_d;
    logic [FLAGS_W-1:0]   flags_q, flags_d;

    logic [W-1:0]         b_eff;
    logic                 sign_a, sign_b;
    logic [EXP_W-1:0]     exp_a, exp_b;
    logic [MAN_W:0]       man_a, man_b;
    fp_class_e            cls_a, cls_b;

    assign b_eff = b ^ {op, {(W-1){1'b0}}};

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .op_i   (a),
        .sign_o (sign_a),
        .exp_o  (exp_a),
        .man_o  (man_a),
        .cls_o  (cls_a)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .op_i   (b_eff),
        .sign_o (sign_b),
        .exp_o  (exp_b),
        .man_o  (man_b),
        .cls_o  (cls_b)
    );

    logic               special;
    logic [W-1:0]       spec_res;
    logic [FLAGS_W-1:0] spec_flags;

    always_comb begin
        special    = (cls_a != CLS_NORM) || (cls_b != CLS_NORM);
        spec_res   = a;
        spec_flags = '0;
        if ((cls_a == CLS_NAN) || (cls_b == CLS_NAN) ||
            ((cls_a == CLS_INF) && (cls_b == CLS_INF) && (sign_a != sign_b))) begin
            spec_res                 = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
        end else if (cls_a == CLS_INF) begin
            spec_res = a;
        end else if (cls_b == CLS_INF) begin
            spec_res = b_eff;
        end else if ((cls_a == CLS_ZERO) && (cls_b == CLS_ZERO)) begin
            spec_res = {sign_a & sign_b, {(W-1){1'b0}}};
        end else if (cls_a == CLS_ZERO) begin
            spec_res = b_eff;
        end
    end

    // Order operands by magnitude at capture so the datapath only ever computes large - small.
    logic             a_ge_b;
    logic             lg_sign;
    logic [EXP_W-1:0] lg_exp, sm_exp, exp_diff;
    logic [MAN_W:0]   lg_man, sm_man;

    assign a_ge_b   = a[W-2:0] >= b_eff[W-2:0];
    assign lg_sign  = a_ge_b ? sign_a : sign_b;
    assign lg_exp   = a_ge_b ? exp_a  : exp_b;
    assign sm_exp   = a_ge_b ? exp_b  : exp_a;
    assign lg_man   = a_ge_b ? man_a  : man_b;
    assign sm_man   = a_ge_b ? man_b  : man_a;
    assign exp_diff = lg_exp - sm_exp;

    logic [MW-1:0]    sum;
    logic             rnd_up;
    logic [MAN_W+1:0] mr;
    logic [EXP_W:0]   e_rnd;
    logic [MAN_W-1:0] frac_rnd;
    logic             inexact;

    assign sum      = sub_q ? (ma_q - mb_q) : (ma_q + mb_q);
    assign inexact  = ma_q[2] | ma_q[1] | ma_q[0];
    assign rnd_up   = ma_q[2] & (ma_q[1] | ma_q[0] | ma_q[3]);
    assign mr       = {1'b0, ma_q[MW-2:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    assign e_rnd    = mr[MAN_W+1] ? (e_q + EXP_ONE) : e_q;
    assign frac_rnd = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];

    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        e_d     = e_q;
        diff_d  = diff_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        res_d   = res_q;
        flags_d = flags_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (special) begin
                        res_d   = spec_res;
                        flags_d = spec_flags;
                        state_d = ST_DONE;
                    end else begin
                        sign_d  = lg_sign;
                        sub_d   = sign_a ^ sign_b;
                        e_d     = {1'b0, lg_exp};
                        ma_d    = {1'b0, lg_man, 3'b000};
                        mb_d    = {1'b0, sm_man, 3'b000};
                        diff_d  = exp_diff;
                        state_d = (exp_diff == '0) ? ST_ADD : ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: begin
                // Beyond SHIFT_MAX every bit of B would land in the sticky bit anyway.
                if (int'(diff_q) > SHIFT_MAX) begin
                    mb_d    = {{(MW-1){1'b0}}, 1'b1};
                    diff_d  = '0;
                    state_d = ST_ADD;
                end else begin
                    mb_d   = {1'b0, mb_q[MW-1:2], mb_q[1] | mb_q[0]};
                    diff_d = diff_q - EXP_W'(1);
                    if (diff_q == EXP_W'(1)) begin
                        state_d = ST_ADD;
                    end
                end
            end
            ST_ADD: begin
                if (sum == '0) begin
                    res_d   = '0;
                    flags_d = '0;
                    state_d = ST_DONE;
                end else begin
                    ma_d    = sum;
                    state_d = (sum[MW-1] || !sum[MW-2]) ? ST_NORM : ST_ROUND;
                end
            end
            ST_NORM: begin
                if (ma_q[MW-1]) begin
                    ma_d    = {1'b0, ma_q[MW-1:2], ma_q[1] | ma_q[0]};
                    e_d     = e_q + EXP_ONE;
                    state_d = ST_ROUND;
                end else if (e_q == EXP_ONE) begin
                    res_d                   = {sign_q, {(W-1){1'b0}}};
                    flags_d                 = '0;
                    flags_d[FLAG_UNDERFLW]  = 1'b1;
                    flags_d[FLAG_INEXACT]   = 1'b1;
                    state_d                 = ST_DONE;
                end else begin
                    ma_d = {ma_q[MW-2:0], 1'b0};
                    e_d  = e_q - EXP_ONE;
                    if (ma_q[MW-3]) begin
                        state_d = ST_ROUND;
                    end
                end
            end
            ST_ROUND: begin
                flags_d               = '0;
                flags_d[FLAG_INEXACT] = inexact;
                if (e_rnd >= EXP_LIM) begin
                    res_d                  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d[FLAG_OVERFLOW] = 1'b1;
                    flags_d[FLAG_INEXACT]  = 1'b1;
                end else begin
                    res_d = {sign_q, e_rnd[EXP_W-1:0], frac_rnd};
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            e_q     <= '0;
            diff_q  <= '0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            e_q     <= e_d;
            diff_q  <= diff_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = res_q;
    assign flags     = flags_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq (half precision): hand-computed results, flags and latencies.
module tb_fp_addsub_seq;
    import fp_pkg::*;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         op        = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [3:0]   flags;
    state_e       state_dbg;

    logic [W+3:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .state_dbg (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Issue one operation, check latency, result and flags, optionally stall the consumer.
    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic opv, input logic [W-1:0] er, input logic [3:0] ef,
                          input int lat, input int hold);
        int           cyc;
        logic [W+3:0] exp_v;
        exp_q.push_back({ef, er});
        check_eq({name, "_in_ready"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        op       = opv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq({name, "_busy"}, 32'(in_ready), 32'd0);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq({name, "_lat"}, 32'(cyc), 32'(lat));
        exp_v = exp_q.pop_front();
        check_eq({name, "_res"}, 32'(result), 32'(exp_v[W-1:0]));
        check_eq({name, "_flags"}, 32'(flags), 32'(exp_v[W+3:W]));
        for (int i = 0; i < hold; i++) begin
            a        = 16'h4400;
            b        = 16'h4400;
            in_valid = 1'b1;
            @(posedge clk); #1;
            check_eq({name, "_hold"}, 32'({out_valid, in_ready, flags, result}),
                     32'({2'b10, exp_v[W+3:W], exp_v[W-1:0]}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq({name, "_idle"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_flags", 32'(flags), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        //       name          a         b         op    result    flags    lat hold
        run_op("add_basic",  16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000, 4,  0);
        run_op("sub_exact",  16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000, 2,  0);
        run_op("neg_zeros",  16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000, 1,  0);
        run_op("overflow",   16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101, 4,  0);
        run_op("inf_inf",    16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b1000, 1,  0);
        run_op("tie_even",   16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001, 14, 0);
        run_op("tie_odd",    16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001, 14, 0);
        run_op("norm_left",  16'h4000, 16'h3C00, 1'b1, 16'h3C00, 4'b0000, 5,  0);
        run_op("carry",      16'h3E00, 16'h3E00, 1'b0, 16'h4200, 4'b0000, 4,  0);
        run_op("underflow",  16'h0401, 16'h0400, 1'b1, 16'h0000, 4'b0011, 3,  0);
        run_op("neg_result", 16'hC000, 16'h3C00, 1'b0, 16'hBC00, 4'b0000, 5,  0);
        run_op("zero_a",     16'h0000, 16'hC500, 1'b0, 16'hC500, 4'b0000, 1,  0);
        run_op("nan_in",     16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 4'b1000, 1,  0);
        run_op("neg_inf",    16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 4'b0000, 1,  0);
        run_op("sub_negz",   16'h3C00, 16'h8000, 1'b1, 16'h3C00, 4'b0000, 1,  0);
        run_op("hold",       16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000, 4,  5);

        // Reset in the middle of alignment drops the operation.
        a        = 16'h3C00;
        b        = 16'h0400;
        op       = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("midrst_align", 32'(state_dbg), 32'(ST_ALIGN));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_eq("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
        check_eq("midrst_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_result", 32'({flags, result}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("midrst_quiet", 32'({out_valid, in_ready}), 32'b01);

        run_op("after_rst",  16'h3C00, 16'h4000, 1'b0, 16'h4200, 4'b0000, 4,  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
